axon_spike_scheduler: RTL

//  Sequences the 16x32 axon weight-type SRAM for one neuron core: buffers incoming axon spikes in a FIFO,
//  and on each timestep tick replays exactly the spikes queued before the tick through the SRAM read port
//  (send_spike/axon_ind), forwarding each 2-bit weight type to the neuron accumulator. Between timesteps it

---
 rtl/axon_spike_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/axon_spike_scheduler.sv
// Spike FIFO plus timestep sequencer for one neuron core's axon weight-type SRAM.
// Between ticks it passes host writes to the SRAM. On a tick it replays the queued spikes through the SRAM read port.
module axon_spike_scheduler #(
    parameter int FIFO_DEPTH = 16,
    parameter int AXON_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              spike_valid_i,
    input  logic [AXON_W-1:0] spike_axon_i,
    output logic              spike_ready_o,
    input  logic              tick_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              tick_overrun_o,
    input  logic              cfg_req_i,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic [DATA_W-1:0] cfg_data_i,
    output logic              cfg_gnt_o,
    output logic              wgt_en_o,
    output logic              wgt_we_o,
    output logic [ADDR_W-1:0] wgt_addr_o,
    output logic [DATA_W-1:0] wgt_d_o,
    output logic              send_spike_o,
    output logic [AXON_W-1:0] axon_ind_o,
    input  logic [1:0]        weight_type_i,
    output logic              acc_valid_o,
    output logic [AXON_W-1:0] acc_axon_o,
    output logic [1:0]        acc_weight_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [AXON_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  rem_reg;
    logic [CNT_W-1:0]  rem_next;
    logic [1:0]        state_reg;
    logic [1:0]        state_next;

    logic              acc_valid_reg;
    logic [AXON_W-1:0] acc_axon_reg;
    logic [1:0]        acc_weight_reg;
    logic              tick_overrun_reg;

    logic push;
    logic pop;
    logic in_idle;

    assign in_idle       = (state_reg == ST_IDLE);
    assign spike_ready_o = (count_reg != CNT_W'(FIFO_DEPTH));
    assign push          = spike_valid_i & spike_ready_o;
    // rem never exceeds occupancy, so a pop in RUN always has a valid head.
    assign pop           = (state_reg == ST_RUN);

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= spike_axon_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // The replay length is the pre-push occupancy; spikes arriving later wait for the next tick.
    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        case (state_reg)
            ST_IDLE: begin
                if (tick_i) begin
                    rem_next   = count_reg;
                    state_next = (count_reg != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                rem_next = rem_reg - CNT_W'(1);
                if (rem_reg == CNT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                rem_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg        <= ST_IDLE;
            rem_reg          <= '0;
            acc_valid_reg    <= 1'b0;
            acc_axon_reg     <= '0;
            acc_weight_reg   <= '0;
            tick_overrun_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            rem_reg          <= rem_next;
            acc_valid_reg    <= pop;
            tick_overrun_reg <= tick_i & ~in_idle;
            if (pop) begin
                acc_axon_reg   <= axon_ind_o;
                acc_weight_reg <= weight_type_i;
            end
        end
    end

    // A tick takes priority over a host write in the same idle cycle, so the host has to retry.
    assign cfg_gnt_o  = in_idle & ~tick_i & cfg_req_i;
    assign wgt_en_o   = cfg_gnt_o;
    assign wgt_we_o   = cfg_gnt_o;
    assign wgt_addr_o = cfg_gnt_o ? cfg_addr_i : '0;
    assign wgt_d_o    = cfg_gnt_o ? cfg_data_i : '0;

    assign send_spike_o   = pop;
    assign axon_ind_o     = pop ? fifo_mem[rd_ptr_reg] : '0;
    assign busy_o         = ~in_idle;
    assign done_o         = (state_reg == ST_DONE);
    assign tick_overrun_o = tick_overrun_reg;
    assign acc_valid_o    = acc_valid_reg;
    assign acc_axon_o     = acc_axon_reg;
    assign acc_weight_o   = acc_weight_reg;

endmodule
